microcode_sequencer: RTL and testbench
======================================

MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 SHALL have parameter IRQ_ENTRY, default 9'h0D3 (unused LR35902 opcode slot): microcode address injected for interrupt entry.
REQ-002 SHALL have parameter CB_PREFIX, default 8'hCB: prefix byte selecting the extended opcode page.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 instr_data  input  8  opcode byte from memory bus.
REQ-006 instr_valid  input  1  instr_data valid this cycle.
REQ-007 fetch_req  output  1  request next opcode byte.
REQ-008 ucode_addr  output  9  microcode address driven into the microcode ROM opcode index.
REQ-009 ucode_next  input  9  next-row address field of current control word.
REQ-010 ucode_end  input  1  control-word flag: last row of instruction.
REQ-011 ucode_wait  input  1  control-word flag: hold row until mem_ack.
REQ-012 ucode_halt  input  1  control-word flag: enter HALT after this row.
REQ-013 mem_ack  input  1  memory operation of current row complete.
REQ-014 irq  input  1  pending, enabled interrupt (level).
REQ-015 irq_ack  output  1  one-cycle pulse when interrupt entry is taken.
REQ-016 step  output  3  row index within current instruction, saturating at 7.
REQ-017 busy  output  1  high in CB_FETCH or EXEC.

Function
REQ-018 States: FETCH, CB_FETCH, EXEC, HALT; encoding in package.
REQ-019 FETCH: fetch_req=1; if irq=1, SHALL load ucode_addr=IRQ_ENTRY, pulse irq_ack, go EXEC, fetch_req=0 that cycle.
REQ-020 FETCH, irq=0, instr_valid=1, instr_data==CB_PREFIX: go CB_FETCH, ucode_addr unchanged.
REQ-021 FETCH, irq=0, instr_valid=1, other byte: ucode_addr<={1'b0,instr_data}, go EXEC.
REQ-022 CB_FETCH: fetch_req=1; irq ignored; on instr_valid, ucode_addr<={1'b1,instr_data}, go EXEC.
REQ-023 Register-to-ROM latency: control word for ucode_addr is combinational; new ucode_addr appears one cycle after the decision edge.
REQ-024 EXEC row advance condition: ucode_wait=0, or ucode_wait=1 and mem_ack=1; otherwise hold ucode_addr and step.
REQ-025 EXEC advance with ucode_end=0: ucode_addr<=ucode_next, step<=step+1 saturating at 7.
REQ-026 EXEC advance with ucode_end=1: go HALT if ucode_halt=1, else FETCH; step<=0.
REQ-027 ucode_halt with ucode_end=0 SHALL be ignored.
REQ-028 HALT: fetch_req=0; on irq=1 go FETCH (interrupt then taken via REQ-019); no irq_ack in HALT.
REQ-029 fetch_req SHALL be 0 in EXEC and HALT; instr_valid outside FETCH/CB_FETCH ignored.
REQ-030 irq sampled only in FETCH; irq during EXEC/CB_FETCH defers to next FETCH.

Reset
REQ-031 On rst: state=FETCH, ucode_addr=9'h000, step=0, irq_ack=0, busy=0, fetch_req=1 (combinational from FETCH).
REQ-032 rst mid-instruction SHALL abandon the instruction immediately; no partial row completion recorded.
REQ-033 First rising edge after rst deassertion SHALL evaluate FETCH normally.

Structure
REQ-034 Shared package: state enum, IRQ_ENTRY and CB_PREFIX defaults, ucode address width (9).
REQ-035 Single module, no sub-module; step counter inline.

Verification
REQ-036 Fetch 8'h00, ucode_end=1 on first row -> ucode_addr=9'h000, EXEC one cycle, back to FETCH, step=0.
REQ-037 Fetch 8'hCB then 8'h37 -> CB_FETCH, ucode_addr=9'h137, busy=1 through EXEC.
REQ-038 Row with ucode_wait=1, mem_ack low 3 cycles -> ucode_addr and step held 3 cycles, advance on 4th to ucode_next.
REQ-039 irq=1 in FETCH with instr_valid=1 -> ucode_addr=9'h0D3, irq_ack single pulse, instr_data discarded.
REQ-040 Row ucode_end=1, ucode_halt=1 -> HALT, fetch_req=0; irq asserted -> FETCH, then IRQ_ENTRY with irq_ack.
REQ-041 rst asserted mid-EXEC at step=3 -> immediate FETCH, ucode_addr=0, step=0; 10 chained rows -> step saturates at 7.

Source files
------------

// File: rtl/microcode_sequencer_pkg.sv
// Shared definitions for the microcode sequencer: state encoding, address width and
// default entry points.
package microcode_sequencer_pkg;

  localparam int unsigned UcodeAddrW = 9;
  localparam int unsigned StepW      = 3;

  localparam logic [UcodeAddrW-1:0] IrqEntryDefault = 9'h0D3;
  localparam logic [7:0]            CbPrefixDefault = 8'hCB;

  localparam logic [1:0] StFetch   = 2'd0;
  localparam logic [1:0] StCbFetch = 2'd1;
  localparam logic [1:0] StExec    = 2'd2;
  localparam logic [1:0] StHalt    = 2'd3;

  localparam logic [StepW-1:0] StepMax = 3'd7;

  function automatic logic [StepW-1:0] step_inc(input logic [StepW-1:0] s);
    return (s == StepMax) ? StepMax : s + 3'd1;
  endfunction

endpackage

// File: rtl/microcode_sequencer.sv
// Opcode fetch / microcode row sequencer: decodes opcode bytes (with a CB prefix page)
// into microcode ROM addresses and walks rows until the end-of-instruction flag.
module microcode_sequencer
  import microcode_sequencer_pkg::*;
#(
  parameter logic [UcodeAddrW-1:0] IRQ_ENTRY = IrqEntryDefault,
  parameter logic [7:0]            CB_PREFIX = CbPrefixDefault
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            instr_data,
  input  logic                  instr_valid,
  output logic                  fetch_req,
  output logic [UcodeAddrW-1:0] ucode_addr,
  input  logic [UcodeAddrW-1:0] ucode_next,
  input  logic                  ucode_end,
  input  logic                  ucode_wait,
  input  logic                  ucode_halt,
  input  logic                  mem_ack,
  input  logic                  irq,
  output logic                  irq_ack,
  output logic [StepW-1:0]      step,
  output logic                  busy
);

  logic [1:0]            state_q, state_d;
  logic [UcodeAddrW-1:0] addr_q, addr_d;
  logic [StepW-1:0]      step_q, step_d;
  logic                  ack_q, ack_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    step_d  = step_q;
    ack_d   = 1'b0;
    case (state_q)
      StFetch: begin
        if (irq) begin
          addr_d  = IRQ_ENTRY;
          ack_d   = 1'b1;
          step_d  = '0;
          state_d = StExec;
        end else if (instr_valid) begin
          if (instr_data == CB_PREFIX) begin
            state_d = StCbFetch;
          end else begin
            addr_d  = {1'b0, instr_data};
            step_d  = '0;
            state_d = StExec;
          end
        end
      end
      StCbFetch: begin
        if (instr_valid) begin
          addr_d  = {1'b1, instr_data};
          step_d  = '0;
          state_d = StExec;
        end
      end
      StExec: begin
        // A waiting row stalls until the memory side acknowledges.
        if (!ucode_wait || mem_ack) begin
          if (ucode_end) begin
            state_d = ucode_halt ? StHalt : StFetch;
            step_d  = '0;
          end else begin
            addr_d = ucode_next;
            step_d = step_inc(step_q);
          end
        end
      end
      StHalt: begin
        if (irq) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      addr_q  <= '0;
      step_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      step_q  <= step_d;
      ack_q   <= ack_d;
    end
  end

  // An interrupt taken this cycle suppresses the opcode request.
  assign fetch_req  = ((state_q == StFetch) && !irq) || (state_q == StCbFetch);
  assign busy       = (state_q == StCbFetch) || (state_q == StExec);
  assign ucode_addr = addr_q;
  assign step       = step_q;
  assign irq_ack    = ack_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer with a queue of expected output snapshots.
module tb_microcode_sequencer;

  logic       clk, rst;
  logic [7:0] instr_data;
  logic       instr_valid;
  logic       fetch_req;
  logic [8:0] ucode_addr;
  logic [8:0] ucode_next;
  logic       ucode_end, ucode_wait, ucode_halt, mem_ack, irq;
  logic       irq_ack;
  logic [2:0] step;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [8:0] addr;
    logic [2:0] step;
    logic       fetch;
    logic       busy;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];

  microcode_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .instr_data (instr_data),
    .instr_valid(instr_valid),
    .fetch_req  (fetch_req),
    .ucode_addr (ucode_addr),
    .ucode_next (ucode_next),
    .ucode_end  (ucode_end),
    .ucode_wait (ucode_wait),
    .ucode_halt (ucode_halt),
    .mem_ack    (mem_ack),
    .irq        (irq),
    .irq_ack    (irq_ack),
    .step       (step),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic drv(input logic v, input logic [7:0] d, input logic i, input logic [8:0] nx,
                     input logic e, input logic w, input logic h, input logic a);
    instr_valid = v; instr_data = d; irq = i; ucode_next = nx;
    ucode_end = e; ucode_wait = w; ucode_halt = h; mem_ack = a;
  endtask

  task automatic expect_out(input string tag, input logic [8:0] a, input logic [2:0] s,
                            input logic f, input logic b, input logic k);
    exp_t e;
    e.tag = tag; e.addr = a; e.step = s; e.fetch = f; e.busy = b; e.ack = k;
    exp_q.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    logic [14:0] got, want;
    while (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      got  = {ucode_addr, step, fetch_req, busy, irq_ack};
      want = {e.addr, e.step, e.fetch, e.busy, e.ack};
      checks++;
      assert (got === want) else begin
        errors++;
        $error("FAIL %s: got addr=%h step=%0d fetch=%b busy=%b ack=%b, want addr=%h step=%0d fetch=%b busy=%b ack=%b",
               e.tag, ucode_addr, step, fetch_req, busy, irq_ack,
               e.addr, e.step, e.fetch, e.busy, e.ack);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    check_now();
  endtask

  initial begin
    rst = 1'b1;
    drv(1'b0, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    expect_out("reset", 9'h000, 3'd0, 1'b1, 1'b0, 1'b0);
    check_now();
    cyc();
    rst = 1'b0;

    // Single-row opcode 00
    drv(1'b1, 8'h00, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("op00_exec", 9'h000, 3'd0, 1'b0, 1'b1, 1'b0); cyc();
    drv(1'b0, 8'h00, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("op00_fetch", 9'h000, 3'd0, 1'b1, 1'b0, 1'b0); cyc();

    // Two-row opcode 42
    drv(1'b1, 8'h42, 1'b0, 9'h055, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("op42_row0", 9'h042, 3'd0, 1'b0, 1'b1, 1'b0); cyc();
    drv(1'b0, 8'h00, 1'b0, 9'h055, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("op42_row1", 9'h055, 3'd1, 1'b0, 1'b1, 1'b0); cyc();
    drv(1'b0, 8'h00, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("op42_end", 9'h055, 3'd0, 1'b1, 1'b0, 1'b0); cyc();

    // CB page; irq during CB_FETCH and EXEC is deferred
    drv(1'b1, 8'hCB, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("cb_fetch", 9'h055, 3'd0, 1'b1, 1'b1, 1'b0); cyc();
    drv(1'b1, 8'h37, 1'b1, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("cb37_exec", 9'h137, 3'd0, 1'b0, 1'b1, 1'b0); cyc();
    drv(1'b0, 8'h00, 1'b1, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("cb37_end_irq_pend", 9'h137, 3'd0, 1'b0, 1'b0, 1'b0); cyc();

    // Interrupt taken in FETCH, opcode discarded
    drv(1'b1, 8'h11, 1'b1, 9'h0A0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("irq_entry", 9'h0D3, 3'd0, 1'b0, 1'b1, 1'b1); cyc();
    drv(1'b0, 8'h00, 1'b0, 9'h0A0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("irq_row1_ack_low", 9'h0A0, 3'd1, 1'b0, 1'b1, 1'b0); cyc();

    // Wait row held three cycles, advances on ack
    drv(1'b0, 8'h00, 1'b0, 9'h0B0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("wait_hold%0d", i), 9'h0A0, 3'd1, 1'b0, 1'b1, 1'b0); cyc();
    end
    drv(1'b0, 8'h00, 1'b0, 9'h0B0, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_out("wait_adv", 9'h0B0, 3'd2, 1'b0, 1'b1, 1'b0); cyc();

    // Halt flag without end is ignored
    drv(1'b0, 8'h00, 1'b0, 9'h0B1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("halt_no_end", 9'h0B1, 3'd3, 1'b0, 1'b1, 1'b0); cyc();
    drv(1'b0, 8'h00, 1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_out("halt_enter", 9'h0B1, 3'd0, 1'b0, 1'b0, 1'b0); cyc();
    drv(1'b1, 8'h22, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("halt_stay", 9'h0B1, 3'd0, 1'b0, 1'b0, 1'b0); cyc();
    drv(1'b0, 8'h00, 1'b1, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("halt_wake", 9'h0B1, 3'd0, 1'b0, 1'b0, 1'b0); cyc();
    expect_out("halt_irq_entry", 9'h0D3, 3'd0, 1'b0, 1'b1, 1'b1); cyc();
    drv(1'b0, 8'h00, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("halt_irq_done", 9'h0D3, 3'd0, 1'b1, 1'b0, 1'b0); cyc();

    // Reset mid-instruction at step 3
    drv(1'b1, 8'h10, 1'b0, 9'h020, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("op10_row0", 9'h010, 3'd0, 1'b0, 1'b1, 1'b0); cyc();
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 8'h00, 1'b0, 9'h020 + 9'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out($sformatf("op10_row%0d", i + 1), 9'h020 + 9'(i), 3'(i + 1), 1'b0, 1'b1, 1'b0);
      cyc();
    end
    rst = 1'b1;
    #1;
    expect_out("mid_reset", 9'h000, 3'd0, 1'b1, 1'b0, 1'b0);
    check_now();
    expect_out("mid_reset_hold", 9'h000, 3'd0, 1'b1, 1'b0, 1'b0); cyc();
    rst = 1'b0;

    // First edge after reset decodes; then ten chained rows saturate step
    drv(1'b1, 8'h30, 1'b0, 9'h040, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("post_reset_fetch", 9'h030, 3'd0, 1'b0, 1'b1, 1'b0); cyc();
    for (int i = 0; i < 10; i++) begin
      drv(1'b0, 8'h00, 1'b0, 9'h040 + 9'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out($sformatf("chain%0d", i), 9'h040 + 9'(i), (i + 1 > 7) ? 3'd7 : 3'(i + 1),
                 1'b0, 1'b1, 1'b0);
      cyc();
    end
    drv(1'b0, 8'h00, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("chain_end", 9'h049, 3'd0, 1'b1, 1'b0, 1'b0); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
